// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, assembles one- and two-word instructions,
// and handles branch redirect, stall and interrupt injection into the IF/ID register.
module fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0020),
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(32'h0000_0010)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              interrupt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic              ifid_valid,
  output logic [15:0]       ifid_instr,
  output logic [15:0]       ifid_imm,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic              ifid_int
);

  localparam logic [15:0] INT_INSTR = 16'hF800;

  typedef enum logic {FETCH, IMM} state_t;

  function automatic logic is_two_word(input logic [15:0] w);
    return (w[15:11] == 5'b01110) || (w[15:11] == 5'b01111) || (w[15:11] == 5'b10000);
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       hold;
  logic              int_prev;
  logic              int_pending;
  logic              int_edge;
  logic              inject;
  logic [ADDR_W-1:0] pc_inc;

  assign imem_addr = pc;
  assign pc_inc    = pc + ADDR_W'(1);
  assign int_edge  = interrupt & ~int_prev;
  assign inject    = (state == FETCH) & ~stall & ~branch_taken & int_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_VEC;
      state        <= FETCH;
      hold         <= '0;
      int_prev     <= 1'b0;
      int_pending  <= 1'b0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_imm     <= '0;
      ifid_pc_next <= '0;
      ifid_int     <= 1'b0;
    end else begin
      // Edge detection keeps running through stalls and redirects; a new edge
      // in the injection cycle survives as the next pending request.
      int_prev    <= interrupt;
      int_pending <= int_edge | (int_pending & ~inject);

      if (branch_taken) begin
        pc           <= branch_target;
        state        <= FETCH;
        ifid_valid   <= 1'b0;
        ifid_instr   <= '0;
        ifid_imm     <= '0;
        ifid_pc_next <= '0;
        ifid_int     <= 1'b0;
      end else if (!stall) begin
        if (inject) begin
          // The word at pc is not consumed; pc_next returns to it.
          pc           <= INT_VEC;
          ifid_valid   <= 1'b1;
          ifid_int     <= 1'b1;
          ifid_instr   <= INT_INSTR;
          ifid_imm     <= '0;
          ifid_pc_next <= pc;
        end else if (state == IMM) begin
          pc           <= pc_inc;
          state        <= FETCH;
          ifid_valid   <= 1'b1;
          ifid_int     <= 1'b0;
          ifid_instr   <= hold;
          ifid_imm     <= imem_data;
          ifid_pc_next <= pc_inc;
        end else if (is_two_word(imem_data)) begin
          hold         <= imem_data;
          pc           <= pc_inc;
          state        <= IMM;
          ifid_valid   <= 1'b0;
          ifid_int     <= 1'b0;
          ifid_instr   <= '0;
          ifid_imm     <= '0;
          ifid_pc_next <= '0;
        end else begin
          pc           <= pc_inc;
          ifid_valid   <= 1'b1;
          ifid_int     <= 1'b0;
          ifid_instr   <= imem_data;
          ifid_imm     <= '0;
          ifid_pc_next <= pc_inc;
        end
      end
    end
  end

endmodule
